emergency_sequencer: RTL

//   Sequences the car through an emergency stop once any emergency source is raised:

---
 rtl/emergency_sequencer_pkg.sv | 52 +++++
 rtl/emergency_sequencer_sos_debounce.sv | 26 ++
 rtl/emergency_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/emergency_sequencer_pkg.sv
// Shared state encodings, cause codes and output decode for the emergency sequencer.
package emergency_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_CREEP = 3'd2,
    ST_OPEN  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_STUCK = 3'd5
  } state_t;

  // Cause codes are ordered by priority, so an upgrade is a numeric max.
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_OVERLOAD = 2'b01;
  localparam logic [1:0] CAUSE_SOS      = 2'b10;
  localparam logic [1:0] CAUSE_FIRE     = 2'b11;

  typedef struct packed {
    logic sos_mode;
    logic motor_stop;
    logic creep_en;
    logic door_open_cmd;
    logic buzzer;
  } outs_t;

  function automatic logic [1:0] source_cause(input logic fire, input logic sos, input logic ovl);
    if (fire)     return CAUSE_FIRE;
    else if (sos) return CAUSE_SOS;
    else if (ovl) return CAUSE_OVERLOAD;
    else          return CAUSE_NONE;
  endfunction

  function automatic outs_t decode_outputs(input state_t st, input logic [1:0] cause);
    outs_t o;
    o = '0;
    case (st)
      ST_HALT:  begin o.sos_mode = 1'b1; o.motor_stop = 1'b1; o.buzzer = 1'b1; end
      ST_CREEP: begin o.sos_mode = 1'b1; o.creep_en = 1'b1; o.buzzer = 1'b1; end
      ST_OPEN:  begin o.sos_mode = 1'b1; o.motor_stop = 1'b1; o.door_open_cmd = 1'b1; o.buzzer = 1'b1; end
      // Overload alone is not a hazard once the door is open, so it stays quiet.
      ST_HOLD:  begin
        o.sos_mode = 1'b1; o.motor_stop = 1'b1; o.door_open_cmd = 1'b1;
        o.buzzer = (cause != CAUSE_OVERLOAD);
      end
      ST_STUCK: begin o.sos_mode = 1'b1; o.motor_stop = 1'b1; o.buzzer = 1'b1; end
      default:  o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/emergency_sequencer_sos_debounce.sv
// SOS button debounce: one event per press after DEBOUNCE consecutive high samples.
module sos_debounce #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);

  localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEBOUNCE);

  logic [CNT_W-1:0] cnt;

  // Count consecutive high samples; parking at FULL suppresses repeats until release.
  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (!btn)        cnt <= '0;
    else if (cnt != CNT_FULL) cnt <= cnt + 1'b1;
  end

  assign evt = btn && (cnt == CNT_TC);

endmodule

// File: rtl/emergency_sequencer.sv
// Emergency stop sequencer: halt, creep to a landing, open door, hold for maintenance.
//
// state | meaning
// IDLE  | normal service, no emergency
// HALT  | stopping the motor, waiting for the car to stand still
// CREEP | slow travel toward the next landing, bounded by CREEP_TIMEOUT
// OPEN  | aligned at a landing, door being forced open (one cycle)
// HOLD  | door held open until the maintenance key releases it
// STUCK | creep timed out between landings, door kept shut
module emergency_sequencer
  import emergency_sequencer_pkg::*;
#(
  parameter int DEBOUNCE      = 4,
  parameter int CREEP_TIMEOUT = 200,
  parameter int CLEAR_CYCLES  = 8,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sos_button,
  input  logic       fire_alarm,
  input  logic       overload,
  input  logic       moving,
  input  logic       at_floor,
  input  logic       clear_key,
  output logic       sos_mode,
  output logic       motor_stop,
  output logic       creep_en,
  output logic       door_open_cmd,
  output logic       buzzer,
  output logic [1:0] cause,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] CREEP_TC = CNT_W'(CREEP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CLEAR_TC = CNT_W'(CLEAR_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [1:0]       cause_q, cause_n, src_cause;
  logic             sos_evt, any_src;
  outs_t            outs_q;

  sos_debounce #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) u_sos_debounce (
    .clk (clk),
    .rst (rst),
    .btn (sos_button),
    .evt (sos_evt)
  );

  assign src_cause = source_cause(fire_alarm, sos_evt, overload);
  // Release needs the raw button low too, not just the absence of a fresh event.
  assign any_src   = fire_alarm | overload | sos_button;

  // Next-state, shared timer and cause latch/upgrade.
  always_comb begin
    state_n = state;
    cause_n = cause_q;
    timer_n = (timer == '1) ? timer : timer + 1'b1;
    if (state != ST_IDLE && src_cause > cause_q) cause_n = src_cause;
    case (state)
      ST_IDLE: begin
        timer_n = '0;
        if (src_cause != CAUSE_NONE) begin
          cause_n = src_cause;
          state_n = (at_floor && !moving) ? ST_OPEN : ST_HALT;
        end
      end
      ST_HALT: begin
        if (!moving) state_n = at_floor ? ST_OPEN : ST_CREEP;
      end
      ST_CREEP: begin
        if (at_floor)                state_n = ST_OPEN;
        else if (timer == CREEP_TC)  state_n = ST_STUCK;
      end
      ST_OPEN: state_n = ST_HOLD;
      ST_HOLD, ST_STUCK: begin
        if (!clear_key) timer_n = '0;
        else if (timer == CLEAR_TC) begin
          if (any_src) timer_n = '0;
          else         state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (state_n != state) timer_n = '0;
    if (state != ST_IDLE && state_n == ST_IDLE) cause_n = CAUSE_NONE;
  end

  // State, timer, cause and output registers; reset drops everything immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      timer   <= '0;
      cause_q <= CAUSE_NONE;
      outs_q  <= '0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      cause_q <= cause_n;
      outs_q  <= decode_outputs(state_n, cause_n);
    end
  end

  assign sos_mode      = outs_q.sos_mode;
  assign motor_stop    = outs_q.motor_stop;
  assign creep_en      = outs_q.creep_en;
  assign door_open_cmd = outs_q.door_open_cmd;
  assign buzzer        = outs_q.buzzer;
  assign cause         = cause_q;
  assign state_o       = state;

endmodule
